// File: rtl/demux1to2_32bit_reg_pkg.sv
// rtl/demux1to2_32bit_reg_pkg.sv - shared constants and types for the registered 1-to-2 word demux
package demux1to2_32bit_reg_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // True when the select bit steers the input word to channel ch.
  function automatic logic routes_to(input logic sel, input logic ch);
    return (sel == ch);
  endfunction

endpackage

// File: rtl/demux1to2_32bit_reg_out_slot.sv
// rtl/demux1to2_32bit_reg_out_slot.sv - one-entry registered output slot with wrap-around transfer counter
module demux_out_slot
  import demux1to2_32bit_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             can_accept_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  // Next-state: a drain empties the slot, a load (possibly the same cycle) refills it.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    count_d      = count_q;
    drain        = (state_q == FULL) && ready_i;
    can_accept_o = (state_q == EMPTY) || ready_i;
    if (drain) begin
      state_d = EMPTY;
      count_d = count_q + CNT_ONE;
    end
    if (load_i) begin
      state_d = FULL;
      data_d  = data_i;
    end
  end

  // Slot state, word and counter registers; reset discards any buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/demux1to2_32bit_reg.sv
// rtl/demux1to2_32bit_reg.sv - registered 1-to-2 demux steering one stream into two handshaked channels
module demux1to2_32bit_reg
  import demux1to2_32bit_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  logic can0, can1;
  logic load0, load1;
  logic in_fire;

  // in_ready follows the selected slot only, so a stalled channel never blocks the other.
  always_comb begin
    in_ready = routes_to(in_sel, CH1) ? can1 : can0;
    in_fire  = in_valid && in_ready;
    load0    = in_fire && routes_to(in_sel, CH0);
    load1    = in_fire && routes_to(in_sel, CH1);
  end

  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load0),
    .data_i       (in_data),
    .ready_i      (out0_ready),
    .valid_o      (out0_valid),
    .data_o       (out0_data),
    .can_accept_o (can0),
    .count_o      (out0_count)
  );

  demux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load1),
    .data_i       (in_data),
    .ready_i      (out1_ready),
    .valid_o      (out1_valid),
    .data_o       (out1_data),
    .can_accept_o (can1),
    .count_o      (out1_count)
  );

endmodule
